// File: rtl/arashi_wrr_arbiter.sv
// Weighted round-robin thread arbiter: registered grant held under valid/accept,
// with a per-thread burst of weight+1 consecutive issues before rotation.
module arashi_wrr_arbiter #(
   parameter  int THREAD_NUM_WIDTH = 3,
   parameter  int WEIGHT_WIDTH     = 4,
   localparam int THREAD_NUM       = 1 << THREAD_NUM_WIDTH
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic [THREAD_NUM-1:0]               i_avail,
   input  logic [THREAD_NUM*WEIGHT_WIDTH-1:0]  i_weight,
   input  logic                                i_accept,
   output logic [THREAD_NUM_WIDTH-1:0]         o_thread_id,
   output logic                                o_valid,
   output logic                                o_last
);

   typedef enum logic {IDLE, GRANT} mode_t;

   mode_t                         r_mode;
   logic [THREAD_NUM_WIDTH-1:0]   r_thread_id;
   logic [WEIGHT_WIDTH-1:0]       r_credit;
   logic [THREAD_NUM_WIDTH-1:0]   r_ptr;

   mode_t                         w_mode_nxt;
   logic [THREAD_NUM_WIDTH-1:0]   w_tid_nxt;
   logic [WEIGHT_WIDTH-1:0]       w_credit_nxt;
   logic [THREAD_NUM_WIDTH-1:0]   w_ptr_nxt;
   logic [THREAD_NUM_WIDTH-1:0]   w_search_start;
   logic [THREAD_NUM_WIDTH:0]     w_found;
   logic                          w_cur_avail;

   // Returns {found, index} of the first available thread scanning upward from start.
   // Iterating from the far end lets the nearest hit overwrite earlier ones.
   function automatic logic [THREAD_NUM_WIDTH:0] f_search(
      input logic [THREAD_NUM-1:0]       avail,
      input logic [THREAD_NUM_WIDTH-1:0] start
   );
      logic [THREAD_NUM_WIDTH:0]   res;
      logic [THREAD_NUM_WIDTH-1:0] idx;
      res = '0;
      for (int unsigned k = THREAD_NUM; k > 0; k--) begin
         idx = start + THREAD_NUM_WIDTH'(k - 1);
         if (avail[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   function automatic logic [WEIGHT_WIDTH-1:0] f_weight(
      input logic [THREAD_NUM*WEIGHT_WIDTH-1:0] weight,
      input logic [THREAD_NUM_WIDTH-1:0]        tid
   );
      return weight[tid*WEIGHT_WIDTH +: WEIGHT_WIDTH];
   endfunction

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_mode      <= IDLE;
         r_thread_id <= '0;
         r_credit    <= '0;
         r_ptr       <= '0;
      end else begin
         r_mode      <= w_mode_nxt;
         r_thread_id <= w_tid_nxt;
         r_credit    <= w_credit_nxt;
         r_ptr       <= w_ptr_nxt;
      end
   end

   // One search serves both the idle start (from ptr) and rotation (from thread_id+1).
   always_comb begin
      w_mode_nxt     = r_mode;
      w_tid_nxt      = r_thread_id;
      w_credit_nxt   = r_credit;
      w_ptr_nxt      = r_ptr;
      w_cur_avail    = i_avail[r_thread_id];
      w_search_start = (r_mode == GRANT) ? r_thread_id + THREAD_NUM_WIDTH'(1) : r_ptr;
      w_found        = f_search(i_avail, w_search_start);
      if (r_mode == IDLE) begin
         if (w_found[THREAD_NUM_WIDTH]) begin
            w_mode_nxt   = GRANT;
            w_tid_nxt    = w_found[THREAD_NUM_WIDTH-1:0];
            w_credit_nxt = f_weight(i_weight, w_found[THREAD_NUM_WIDTH-1:0]);
         end else begin
            w_tid_nxt    = '0;
         end
      end else begin
         if (i_accept && (r_credit != '0) && w_cur_avail) begin
            w_credit_nxt = r_credit - WEIGHT_WIDTH'(1);
         end else if (i_accept || !w_cur_avail) begin
            w_ptr_nxt = r_thread_id + THREAD_NUM_WIDTH'(1);
            if (w_found[THREAD_NUM_WIDTH]) begin
               w_tid_nxt    = w_found[THREAD_NUM_WIDTH-1:0];
               w_credit_nxt = f_weight(i_weight, w_found[THREAD_NUM_WIDTH-1:0]);
            end else begin
               w_mode_nxt   = IDLE;
               w_tid_nxt    = '0;
               w_credit_nxt = '0;
            end
         end
      end
   end

   always_comb begin
      o_thread_id = r_thread_id;
      o_valid     = (r_mode == GRANT);
      o_last      = (r_mode == GRANT) && (r_credit == '0);
   end

endmodule

// File: tb/tb_arashi_wrr_arbiter.sv
// Bench for arashi_wrr_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_arashi_wrr_arbiter;

   logic        clk;
   logic        rstn;
   logic [7:0]  i_avail;
   logic [31:0] i_weight;
   logic        i_accept;
   logic [2:0]  o_thread_id;
   logic        o_valid;
   logic        o_last;

   int errors = 0;
   int checks = 0;

   int rr_exp[6]    = '{0, 2, 7, 0, 2, 7};
   int wb_tid[10]   = '{0, 2, 2, 2, 2, 0, 2, 2, 2, 2};
   int wb_last[10]  = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 1};
   int hold_last[3] = '{0, 1, 0};
   int rst_seq[10]  = '{0, 3, 3, 3, 3, 3, 3, 3, 3, 0};

   arashi_wrr_arbiter #(.THREAD_NUM_WIDTH(3), .WEIGHT_WIDTH(4)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .i_avail     (i_avail),
      .i_weight    (i_weight),
      .i_accept    (i_accept),
      .o_thread_id (o_thread_id),
      .o_valid     (o_valid),
      .o_last      (o_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int first_avail(input logic [7:0] a, input int s);
      for (int k = 0; k < 8; k++)
         if (a[(s + k) % 8]) return (s + k) % 8;
      return -1;
   endfunction

   // Behavioural model: turn = thread plus remaining issues; checked each cycle.
   initial begin
      int m_valid, m_tid, m_credit, m_ptr, nxt;
      logic [7:0]  a;
      logic [31:0] w;
      logic        acc, rs;
      m_valid = 0; m_tid = 0; m_credit = 0; m_ptr = 0;
      forever begin
         @(posedge clk);
         a = i_avail; w = i_weight; acc = i_accept; rs = rstn;
         if (!rs) begin
            m_valid = 0; m_tid = 0; m_credit = 0; m_ptr = 0;
         end else if (m_valid == 0) begin
            nxt = first_avail(a, m_ptr);
            if (nxt >= 0) begin
               m_valid = 1; m_tid = nxt; m_credit = int'(w[nxt*4 +: 4]);
            end else begin
               m_tid = 0;
            end
         end else if (acc && m_credit > 0 && a[m_tid]) begin
            m_credit = m_credit - 1;
         end else if (acc || !a[m_tid]) begin
            m_ptr = (m_tid + 1) % 8;
            nxt = first_avail(a, m_ptr);
            if (nxt >= 0) begin
               m_tid = nxt; m_credit = int'(w[nxt*4 +: 4]);
            end else begin
               m_valid = 0; m_tid = 0; m_credit = 0;
            end
         end
         #1;
         chk("model_valid", o_valid, m_valid);
         chk("model_tid", o_thread_id, m_tid);
         chk("model_last", o_last, (m_valid == 1 && m_credit == 0) ? 1 : 0);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rstn = 1'b0; i_avail = '0; i_accept = 1'b0;
      cyc();
      chk("reset_valid", o_valid, 0);
      chk("reset_tid", o_thread_id, 0);
      chk("reset_last", o_last, 0);
      rstn = 1'b1;
   endtask

   initial begin
      logic [7:0] tmp;
      rstn = 1'b0; i_avail = '0; i_accept = 1'b0; i_weight = '0;

      do_reset();
      i_weight = '0; i_avail = 8'b1000_0101; i_accept = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cyc();
         chk("rr_tid", o_thread_id, rr_exp[k]);
         chk("rr_valid", o_valid, 1);
         chk("rr_last", o_last, 1);
      end

      do_reset();
      i_weight = '0; i_weight[2*4 +: 4] = 4'd3; i_avail = 8'b0000_0101; i_accept = 1'b1;
      for (int k = 0; k < 10; k++) begin
         cyc();
         chk("burst_tid", o_thread_id, wb_tid[k]);
         chk("burst_last", o_last, wb_last[k]);
      end

      do_reset();
      i_weight = '0; i_weight[2*4 +: 4] = 4'd2; i_avail = 8'b0000_0100; i_accept = 1'b0;
      for (int k = 0; k < 6; k++) begin
         cyc();
         chk("hold_tid", o_thread_id, 2);
         chk("hold_last", o_last, 0);
      end
      i_accept = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("hold_acc_tid", o_thread_id, 2);
         chk("hold_acc_last", o_last, hold_last[k]);
      end

      do_reset();
      i_weight = '0; i_avail = 8'b0100_0100; i_accept = 1'b0;
      cyc();
      chk("wd_first", o_thread_id, 2);
      i_avail = 8'b0100_0000;
      cyc();
      chk("wd_tid", o_thread_id, 6);
      chk("wd_valid", o_valid, 1);
      i_avail = 8'b0000_0000;
      cyc();
      chk("wd_empty_valid", o_valid, 0);
      chk("wd_empty_tid", o_thread_id, 0);

      do_reset();
      i_weight = '0; i_avail = 8'b0010_0000; i_accept = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("lone_tid", o_thread_id, 5);
         chk("lone_valid", o_valid, 1);
         chk("lone_last", o_last, 1);
      end

      do_reset();
      i_weight = '0; i_weight[3*4 +: 4] = 4'd7; i_avail = 8'b0000_1000; i_accept = 1'b1;
      for (int k = 0; k < 4; k++) cyc();
      chk("mid_tid", o_thread_id, 3);
      chk("mid_last", o_last, 0);
      rstn = 1'b0;
      cyc();
      chk("mid_rst_valid", o_valid, 0);
      chk("mid_rst_tid", o_thread_id, 0);
      chk("mid_rst_last", o_last, 0);
      rstn = 1'b1; i_avail = 8'b0000_1001;
      for (int k = 0; k < 10; k++) begin
         cyc();
         chk("post_rst_tid", o_thread_id, rst_seq[k]);
      end

      i_weight = $urandom();
      for (int n = 0; n < 3000; n++) begin
         rstn = ($urandom_range(0, 99) != 0);
         if ($urandom_range(0, 9) < 3) begin
            case ($urandom_range(0, 3))
               0:       i_avail = '0;
               1: begin tmp = 8'd1; i_avail = tmp << $urandom_range(0, 7); end
               default: i_avail = 8'($urandom());
            endcase
         end
         i_accept = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 19) == 0) i_weight = $urandom() & 32'h3333_3333;
         cyc();
      end

      cyc();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
